// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer
// Description : Packs 24-bit RGB pixels into 32-bit AXI4-Stream words
//               (4 pixels -> 3 words) with start-of-frame and end-of-line marks.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_packer #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_done
);

    localparam int c_X_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int c_Y_W = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [c_X_W-1:0] c_X_MAX = c_X_W'(X_SIZE - 1);
    localparam logic [c_Y_W-1:0] c_Y_MAX = c_Y_W'(Y_SIZE - 1);

    logic [1:0]       r_phase;
    logic [c_X_W-1:0] r_x;
    logic [c_Y_W-1:0] r_y;
    logic [23:0]      r_stage;
    logic [31:0]      r_tdata;
    logic             r_tvalid;
    logic             r_tlast;
    logic             r_tuser;
    logic             r_frame_end;
    logic             r_frame_done;

    logic             w_pix_hs;
    logic             w_out_hs;
    logic             w_load;
    logic             w_x_max;
    logic             w_y_max;
    logic             w_tlast;
    logic             w_tuser;
    logic [31:0]      w_word;
    logic [23:0]      w_stage_nxt;

    assign in_ready = (r_phase == 2'd0) || !r_tvalid || m_axis_tready;
    assign w_pix_hs = in_valid && in_ready;
    assign w_out_hs = r_tvalid && m_axis_tready;
    assign w_load   = w_pix_hs && (r_phase != 2'd0);
    assign w_x_max  = (r_x == c_X_MAX);
    assign w_y_max  = (r_y == c_Y_MAX);
    assign w_tlast  = (r_phase == 2'd3) && w_x_max;
    assign w_tuser  = (r_phase == 2'd1) && (r_x == c_X_W'(1)) && (r_y == '0);

    // Staging keeps the leftover bytes, lowest stream byte in the low lane.
    always_comb begin
        w_word      = '0;
        w_stage_nxt = r_stage;
        case (r_phase)
            2'd0: begin
                w_stage_nxt = {in_b, in_g, in_r};
            end
            2'd1: begin
                w_word      = {in_r, r_stage};
                w_stage_nxt = {8'h00, in_b, in_g};
            end
            2'd2: begin
                w_word      = {in_g, in_r, r_stage[15:0]};
                w_stage_nxt = {16'h0000, in_b};
            end
            default: begin
                w_word      = {in_b, in_g, in_r, r_stage[7:0]};
                w_stage_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_phase <= 2'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_stage <= '0;
        end else if (w_pix_hs) begin
            r_phase <= r_phase + 2'd1;
            r_stage <= w_stage_nxt;
            if (w_x_max) begin
                r_x <= '0;
                r_y <= w_y_max ? '0 : r_y + c_Y_W'(1);
            end else begin
                r_x <= r_x + c_X_W'(1);
            end
        end
    end

    // A new word may replace the one being accepted in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tuser      <= 1'b0;
            r_frame_end  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_hs && r_tlast && r_frame_end;
            if (w_load) begin
                r_tdata     <= w_word;
                r_tvalid    <= 1'b1;
                r_tlast     <= w_tlast;
                r_tuser     <= w_tuser;
                r_frame_end <= w_tlast && w_y_max;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign frame_done    = r_frame_done;

endmodule
`default_nettype wire
